// File: rtl/load_store_unit.sv
// RV32I load/store unit: one memory request per core op, byte/half/word lanes, timeout and illegal-op errors.
// Optional LSU_MISALIGN_TRAP_EN: trap misaligned half/word accesses (err_cause 01) instead of ignoring low bits.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] load_data,
  output logic        done,
  output logic        busy,
  output logic        err,
  output logic [1:0]  err_cause
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_reg, state_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] sdata_reg, sdata_next;
  logic [2:0]  funct3_reg, funct3_next;
  logic        load_reg, load_next;
  logic        err_reg, err_next;
  logic [1:0]  cause_reg, cause_next;
  logic [31:0] ldata_reg, ldata_next;
  logic [7:0]  cnt_reg, cnt_next;

  logic        illegal_in;
  logic        misalign_in;
  logic [7:0]  rlane [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;
  logic [3:0]  be_lat;
  logic [31:0] wdata_lat;

  // Request classification on the raw inputs, evaluated in IDLE before latching.
  always_comb begin
    illegal_in = (is_load == is_store)
              || (is_load && (funct3 == 3'b011 || funct3[2:1] == 2'b11))
              || (is_store && funct3[2]);
`ifdef LSU_MISALIGN_TRAP_EN
    misalign_in = (funct3[1:0] == 2'b01 && addr[0])
               || (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
`else
    misalign_in = 1'b0;
`endif
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign rlane[gi] = mem_rdata[8*gi +: 8];
    end
  endgenerate

  assign byte_sel = rlane[addr_reg[1:0]];
  assign half_sel = addr_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    load_ext = 32'h0;
    if (load_reg) begin
      case (funct3_reg)
        3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
        3'b100:  load_ext = {24'h0, byte_sel};
        3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
        3'b101:  load_ext = {16'h0, half_sel};
        3'b010:  load_ext = mem_rdata;
        default: load_ext = 32'h0;
      endcase
    end
  end

  // Byte enables and replicated write data derived from the latched request.
  always_comb begin
    be_lat    = 4'b1111;
    wdata_lat = 32'h0;
    if (!load_reg) begin
      case (funct3_reg[1:0])
        2'b00: begin
          be_lat    = 4'b0001 << addr_reg[1:0];
          wdata_lat = {4{sdata_reg[7:0]}};
        end
        2'b01: begin
          be_lat    = 4'b0011 << {addr_reg[1], 1'b0};
          wdata_lat = {2{sdata_reg[15:0]}};
        end
        default: begin
          be_lat    = 4'b1111;
          wdata_lat = sdata_reg;
        end
      endcase
    end
  end

  always_comb begin
    state_next  = state_reg;
    addr_next   = addr_reg;
    sdata_next  = sdata_reg;
    funct3_next = funct3_reg;
    load_next   = load_reg;
    err_next    = err_reg;
    cause_next  = cause_reg;
    ldata_next  = ldata_reg;
    cnt_next    = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          addr_next   = addr;
          sdata_next  = store_data;
          funct3_next = funct3;
          load_next   = is_load;
          ldata_next  = 32'h0;
          cnt_next    = 8'h0;
          err_next    = 1'b0;
          cause_next  = 2'b00;
          if (illegal_in) begin
            state_next = RESP;
            err_next   = 1'b1;
            cause_next = 2'b11;
          end else if (misalign_in) begin
            state_next = RESP;
            err_next   = 1'b1;
            cause_next = 2'b01;
          end else begin
            state_next = ACCESS;
          end
        end
      end
      ACCESS: begin
        // A ready in the last allowed cycle still completes normally.
        if (mem_ready) begin
          ldata_next = load_ext;
          state_next = RESP;
        end else if (cnt_reg == CNT_LAST) begin
          err_next   = 1'b1;
          cause_next = 2'b10;
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg + 8'h1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      addr_reg   <= 32'h0;
      sdata_reg  <= 32'h0;
      funct3_reg <= 3'b000;
      load_reg   <= 1'b0;
      err_reg    <= 1'b0;
      cause_reg  <= 2'b00;
      ldata_reg  <= 32'h0;
      cnt_reg    <= 8'h0;
    end else begin
      state_reg  <= state_next;
      addr_reg   <= addr_next;
      sdata_reg  <= sdata_next;
      funct3_reg <= funct3_next;
      load_reg   <= load_next;
      err_reg    <= err_next;
      cause_reg  <= cause_next;
      ldata_reg  <= ldata_next;
      cnt_reg    <= cnt_next;
    end
  end

  assign mem_req   = (state_reg == ACCESS);
  assign mem_we    = mem_req && !load_reg;
  assign mem_addr  = mem_req ? {addr_reg[31:2], 2'b00} : 32'h0;
  assign mem_be    = mem_req ? be_lat : 4'b0000;
  assign mem_wdata = mem_req ? wdata_lat : 32'h0;

  assign done      = (state_reg == RESP);
  assign busy      = (state_reg != IDLE);
  assign load_data = done ? ldata_reg : 32'h0;
  assign err       = done && err_reg;
  assign err_cause = done ? cause_reg : 2'b00;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: expected responses queued at issue, popped and compared on done.
module tb_load_store_unit;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        is_load;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [31:0] load_data;
  logic        done;
  logic        busy;
  logic        err;
  logic [1:0]  err_cause;

  int npass  = 0;
  int ntotal = 0;

  typedef struct {
    logic [31:0] ld;
    logic        err;
    logic [1:0]  cause;
    logic [31:0] maddr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
    int          lat;
    int          nacc;
  } exp_t;

  exp_t sb[$];

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .is_load(is_load), .is_store(is_store),
    .funct3(funct3), .addr(addr), .store_data(store_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .load_data(load_data), .done(done), .busy(busy), .err(err), .err_cause(err_cause)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    ntotal++;
    assert (obs === expv) npass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  // ready_at: index of the ACCESS cycle in which mem_ready is driven (-1 = never).
  task automatic run_op(input string tag, input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d, input logic [31:0] rd,
                        input int ready_at,
                        input logic [31:0] e_ld, input logic e_err, input logic [1:0] e_cause,
                        input logic [31:0] e_maddr, input logic [3:0] e_be, input logic [31:0] e_wdata,
                        input int e_lat, input int e_nacc);
    exp_t e;
    int   nacc;
    logic finished;
    e.ld = e_ld; e.err = e_err; e.cause = e_cause; e.maddr = e_maddr; e.be = e_be;
    e.wdata = e_wdata; e.we = st && !ld; e.lat = e_lat; e.nacc = e_nacc;
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b1; is_load = ld; is_store = st; funct3 = f3; addr = a; store_data = d;
    nacc = 0;
    finished = 1'b0;
    for (int cyc = 1; cyc <= 60 && !finished; cyc++) begin
      @(negedge clk);
      if (cyc == 1) chk({tag, ".busy"}, 32'(busy), 32'd1);
      if (mem_req) begin
        nacc++;
        if (nacc == 1) begin
          chk({tag, ".mem_addr"}, mem_addr, sb[0].maddr);
          chk({tag, ".mem_be"}, 32'(mem_be), 32'(sb[0].be));
          chk({tag, ".mem_we"}, 32'(mem_we), 32'(sb[0].we));
          if (sb[0].we) chk({tag, ".mem_wdata"}, mem_wdata, sb[0].wdata);
        end
        mem_ready = (nacc - 1 == ready_at);
        mem_rdata = rd;
      end else begin
        mem_ready = 1'b0;
      end
      if (done) begin
        e = sb.pop_front();
        chk({tag, ".load_data"}, load_data, e.ld);
        chk({tag, ".err"}, 32'(err), 32'(e.err));
        chk({tag, ".err_cause"}, 32'(err_cause), 32'(e.cause));
        chk({tag, ".latency"}, 32'(cyc), 32'(e.lat));
        chk({tag, ".mem_req_cycles"}, 32'(nacc), 32'(e.nacc));
        req_valid = 1'b0;
        finished = 1'b1;
      end
    end
    if (!finished) begin
      chk({tag, ".done_seen"}, 32'(finished), 32'd1);
      e = sb.pop_front();
      req_valid = 1'b0;
    end
    mem_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3 = 3'b000;
    addr = 32'h0; store_data = 32'h0; mem_ready = 1'b0; mem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("reset.mem_req", 32'(mem_req), 32'd0);
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.done", 32'(done), 32'd0);
    chk("reset.load_data", load_data, 32'h0);
    chk("reset.err", {29'h0, err, err_cause}, 32'h0);
    rst = 1'b0;

    run_op("sb_1003", 1'b0, 1'b1, 3'b000, 32'h1003, 32'hAABBCCDD, 32'h0, 0,
           32'h0, 1'b0, 2'b00, 32'h1000, 4'b1000, 32'hDDDDDDDD, 2, 1);
    run_op("lb_2001", 1'b1, 1'b0, 3'b000, 32'h2001, 32'h0, 32'h12348056, 0,
           32'hFFFFFF80, 1'b0, 2'b00, 32'h2000, 4'b1111, 32'h0, 2, 1);
    run_op("lbu_2001", 1'b1, 1'b0, 3'b100, 32'h2001, 32'h0, 32'h12348056, 0,
           32'h00000080, 1'b0, 2'b00, 32'h2000, 4'b1111, 32'h0, 2, 1);
    run_op("lhu_2002", 1'b1, 1'b0, 3'b101, 32'h2002, 32'h0, 32'h12348056, 0,
           32'h00001234, 1'b0, 2'b00, 32'h2000, 4'b1111, 32'h0, 2, 1);
    run_op("lh_2000", 1'b1, 1'b0, 3'b001, 32'h2000, 32'h0, 32'h00008001, 2,
           32'hFFFF8001, 1'b0, 2'b00, 32'h2000, 4'b1111, 32'h0, 4, 3);
    run_op("lb_2003", 1'b1, 1'b0, 3'b000, 32'h2003, 32'h0, 32'h7F000000, 0,
           32'h0000007F, 1'b0, 2'b00, 32'h2000, 4'b1111, 32'h0, 2, 1);
    run_op("sh_1006", 1'b0, 1'b1, 3'b001, 32'h1006, 32'h1234ABCD, 32'h0, 1,
           32'h0, 1'b0, 2'b00, 32'h1004, 4'b1100, 32'hABCDABCD, 3, 2);
    run_op("sw_1008", 1'b0, 1'b1, 3'b010, 32'h1008, 32'hCAFEF00D, 32'h0, 0,
           32'h0, 1'b0, 2'b00, 32'h1008, 4'b1111, 32'hCAFEF00D, 2, 1);
    run_op("lw_timeout", 1'b1, 1'b0, 3'b010, 32'h4000, 32'h0, 32'h55555555, -1,
           32'h0, 1'b1, 2'b10, 32'h4000, 4'b1111, 32'h0, TO + 1, TO);
    run_op("lw_last_ready", 1'b1, 1'b0, 3'b010, 32'h4004, 32'h0, 32'h11223344, TO - 1,
           32'h11223344, 1'b0, 2'b00, 32'h4004, 4'b1111, 32'h0, TO + 1, TO);
`ifdef LSU_MISALIGN_TRAP_EN
    run_op("lw_3002", 1'b1, 1'b0, 3'b010, 32'h3002, 32'h0, 32'hDEADBEEF, 0,
           32'h0, 1'b1, 2'b01, 32'h0, 4'b0000, 32'h0, 1, 0);
`else
    run_op("lw_3002", 1'b1, 1'b0, 3'b010, 32'h3002, 32'h0, 32'hDEADBEEF, 0,
           32'hDEADBEEF, 1'b0, 2'b00, 32'h3000, 4'b1111, 32'h0, 2, 1);
`endif
    run_op("ill_both", 1'b1, 1'b1, 3'b010, 32'h5000, 32'h0, 32'h0, 0,
           32'h0, 1'b1, 2'b11, 32'h0, 4'b0000, 32'h0, 1, 0);
    run_op("ill_ld011", 1'b1, 1'b0, 3'b011, 32'h5000, 32'h0, 32'h0, 0,
           32'h0, 1'b1, 2'b11, 32'h0, 4'b0000, 32'h0, 1, 0);
    run_op("ill_st100", 1'b0, 1'b1, 3'b100, 32'h5000, 32'h0, 32'h0, 0,
           32'h0, 1'b1, 2'b11, 32'h0, 4'b0000, 32'h0, 1, 0);

    // Reset in the 2nd ACCESS cycle, coinciding with mem_ready: request is abandoned.
    @(negedge clk);
    req_valid = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h6000;
    @(negedge clk);
    chk("rst_mid.acc1", 32'(mem_req), 32'd1);
    @(negedge clk);
    chk("rst_mid.acc2", 32'(mem_req), 32'd1);
    rst = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h99999999; req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0; mem_ready = 1'b0;
    chk("rst_mid.mem_req", 32'(mem_req), 32'd0);
    chk("rst_mid.busy", 32'(busy), 32'd0);
    chk("rst_mid.done", 32'(done), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_mid.no_done", {30'h0, done, busy}, 32'h0);
    end

    chk("sb.empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 64, max ACCESS cycles waiting for mem_ready (legal 1..255).
REQ-002 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  in  1  synchronous, active-high reset.
REQ-004 Port: req_valid  in  1  core requests a memory op; held high until done.
REQ-005 Port: is_load / is_store  in  1 each  op type.
REQ-006 Port: funct3  in  3  RV32I load/store width code.
REQ-007 Port: addr  in  32  effective address (ALU sum output).
REQ-008 Port: store_data  in  32  rs2 value.
REQ-009 Port: mem_req / mem_we  out  1 each  memory request / write strobe.
REQ-010 Port: mem_addr  out  32  word address {addr[31:2],2'b00}.
REQ-011 Port: mem_be  out  4  byte enables; mem_wdata  out  32  lane-replicated store data.
REQ-012 Port: mem_ready  in  1  memory completes access this cycle; mem_rdata  in  32  read word.
REQ-013 Port: load_data  out  32  extended load result; done  out  1  one-cycle completion pulse.
REQ-014 Port: busy  out  1  high whenever state != IDLE (core stall).
REQ-015 Port: err  out  1 / err_cause  out  2  01 misaligned, 10 timeout, 11 illegal op.

Function
REQ-016 FSM states IDLE, ACCESS, RESP; mem_req, busy, done decoded from registered state.
REQ-017 IDLE: req_valid high -> latch addr, store_data, funct3, op; legal aligned -> ACCESS; error -> RESP with err set, no mem_req ever.
REQ-018 Illegal: is_load==is_store, load funct3 in {011,110,111}, store funct3[2]==1 -> err_cause 11.
REQ-019 ACCESS: mem_req=1; mem_addr/mem_we/mem_be/mem_wdata stable from latched values; mem_ready -> RESP.
REQ-020 Timeout counter cleared on ACCESS entry, +1 per ACCESS cycle without mem_ready; after TIMEOUT_CYCLES cycles -> RESP, err_cause 10; mem_ready in final cycle wins (no error).
REQ-021 RESP: done=1 exactly one cycle, load_data/err/err_cause valid that cycle, then IDLE; req_valid ignored in RESP.
REQ-022 Minimum latency: req_valid sampled at edge N, mem_ready at edge N+1 -> done high in cycle after N+1.
REQ-023 mem_be: SB 4'b0001<<addr[1:0]; SH 4'b0011<<{addr[1],1'b0}; SW 4'b1111; loads 4'b1111, mem_we=0.
REQ-024 mem_wdata: SB {4{d[7:0]}}; SH {2{d[15:0]}}; SW d.
REQ-025 Loads: select byte/half by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW whole word; mem_rdata captured at mem_ready edge.
REQ-026 load_data=0 for stores and any errored op; err/err_cause=0 when no error; outputs 0 outside RESP except mem_* in ACCESS.

Reset
REQ-027 rst at any edge -> state IDLE, counter 0, all outputs 0 next cycle, including mid-ACCESS (request abandoned, no done).
REQ-028 rst has priority over mem_ready and req_valid in the same cycle.

Configuration
REQ-029 Macro LSU_MISALIGN_TRAP_EN defined: LH/LHU/SH with addr[0]=1 or LW/SW with addr[1:0]!=0 -> err_cause 01, no memory access.
REQ-030 Macro undefined: no misalignment check; offending low bits ignored (half uses addr[1], word uses lane 0); err_cause 01 never produced.

Verification
REQ-031 SB addr=0x1003 data=0xAABBCCDD, mem_ready 1st cycle -> mem_addr 0x1000, be 1000, wdata 0xDDDDDDDD, done 2 cycles after request.
REQ-032 LB addr=0x2001, rdata=0x12348056 -> load_data 0xFFFFFF80; LBU same -> 0x00000080; LHU addr=0x2002 -> 0x00001234.
REQ-033 LW, mem_ready never asserted, TIMEOUT_CYCLES=4 -> mem_req high exactly 4 cycles, then done, err=1, err_cause 10, load_data 0.
REQ-034 LW addr=0x3002: with LSU_MISALIGN_TRAP_EN -> no mem_req, done next cycle, err_cause 01; without -> mem_addr 0x3000, normal load.
REQ-035 is_load=is_store=1 or load funct3=011 -> no mem_req, err_cause 11; rst asserted in 2nd ACCESS cycle -> mem_req, busy 0 next cycle, no done.
